// File: rtl/safe_code_controller.sv
// -----------------------------------------------------------------------------
// safe_code_controller
//
// Code-entry controller for a keypad safe. It takes the scanner's 4-bit key
// codes, gathers digits into an entry buffer, checks the entry against the
// stored code, and drives the lock. It counts consecutive failed attempts,
// applies a timed lockout once MAX_FAILS is reached, and lets the user change
// the stored code while the safe is unlocked.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-high
//   key_in      in   [3:0] key code: 0-9 digit, 10 hash, 11 star, others no-op
//   locked      out  high in LOCKED or LOCKOUT
//   unlocked    out  high in UNLOCKED or SET_NEW
//   set_mode    out  high in SET_NEW
//   lockout     out  high in LOCKOUT
//   error       out  one-cycle pulse per rejected hash
//   digit_count out  [2:0] digits held in the entry buffer
//   fail_count  out  [3:0] consecutive failed unlock attempts
//
// Every output is registered. The outputs are computed from the next-state
// values, so an event in cycle N shows on the outputs in cycle N+1.
// -----------------------------------------------------------------------------
module safe_code_controller #(
  parameter int                    CODE_LEN       = 4,
  parameter int                    MAX_FAILS      = 3,
  parameter logic [15:0]           LOCKOUT_CYCLES = 16'd1000,
  parameter logic [4*CODE_LEN-1:0] RESET_CODE     = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic       locked,
  output logic       unlocked,
  output logic       set_mode,
  output logic       lockout,
  output logic       error,
  output logic [2:0] digit_count,
  output logic [3:0] fail_count
);

  localparam int         W           = 4 * CODE_LEN;
  localparam logic [2:0] CODE_LEN_C  = 3'(CODE_LEN);
  localparam logic [3:0] MAX_FAILS_C = 4'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_SET_NEW  = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  state_t         state_r, state_s;
  logic [W-1:0]   buf_r, buf_s;
  logic [W-1:0]   stored_r, stored_s;
  logic [2:0]     cnt_r, cnt_s;
  logic           ovf_r, ovf_s;
  logic [15:0]    timer_r, timer_s;
  logic [3:0]     fail_r, fail_s;
  logic           error_s;

  logic           is_digit_s;
  logic           is_hash_s;
  logic           is_star_s;
  logic           full_entry_s;
  logic [W-1:0]   shifted_s;
  logic [3:0]     fail_inc_s;

  assign is_digit_s   = (key_in <= 4'd9);
  assign is_hash_s    = (key_in == 4'd10);
  assign is_star_s    = (key_in == 4'd11);
  // An entry is complete only with exactly CODE_LEN digits and no extra ones.
  assign full_entry_s = (cnt_r == CODE_LEN_C) && !ovf_r;
  // The newest digit goes into the low nibble; the oldest ends up in the top.
  assign shifted_s    = (buf_r << 3'd4) | W'(key_in);
  // Saturate so the counter never passes MAX_FAILS.
  assign fail_inc_s   = (fail_r >= MAX_FAILS_C) ? MAX_FAILS_C : (fail_r + 4'd1);

  // Next-state and datapath logic for all four controller states.
  always_comb begin
    state_s  = state_r;
    buf_s    = buf_r;
    stored_s = stored_r;
    cnt_s    = cnt_r;
    ovf_s    = ovf_r;
    timer_s  = timer_r;
    fail_s   = fail_r;
    error_s  = 1'b0;

    case (state_r)
      ST_LOCKED: begin
        if (is_digit_s) begin
          if (cnt_r < CODE_LEN_C) begin
            buf_s = shifted_s;
            cnt_s = cnt_r + 3'd1;
          end else begin
            ovf_s = 1'b1;
          end
        end else if (is_star_s) begin
          buf_s = '0;
          cnt_s = 3'd0;
          ovf_s = 1'b0;
        end else if (is_hash_s) begin
          buf_s = '0;
          cnt_s = 3'd0;
          ovf_s = 1'b0;
          if (full_entry_s && (buf_r == stored_r)) begin
            state_s = ST_UNLOCKED;
            fail_s  = 4'd0;
          end else begin
            error_s = 1'b1;
            fail_s  = fail_inc_s;
            if (fail_inc_s == MAX_FAILS_C) begin
              state_s = ST_LOCKOUT;
              timer_s = LOCKOUT_CYCLES;
            end else begin
              state_s = ST_LOCKED;
            end
          end
        end else begin
          state_s = ST_LOCKED;
        end
      end

      ST_UNLOCKED: begin
        // Digits are ignored while the safe is open.
        if (is_star_s) begin
          state_s = ST_LOCKED;
          buf_s   = '0;
          cnt_s   = 3'd0;
          ovf_s   = 1'b0;
        end else if (is_hash_s) begin
          state_s = ST_SET_NEW;
          buf_s   = '0;
          cnt_s   = 3'd0;
          ovf_s   = 1'b0;
        end else begin
          state_s = ST_UNLOCKED;
        end
      end

      ST_SET_NEW: begin
        if (is_digit_s) begin
          if (cnt_r < CODE_LEN_C) begin
            buf_s = shifted_s;
            cnt_s = cnt_r + 3'd1;
          end else begin
            ovf_s = 1'b1;
          end
        end else if (is_star_s) begin
          // Star on an empty buffer abandons the change; otherwise it only clears.
          if (cnt_r == 3'd0) begin
            state_s = ST_UNLOCKED;
          end else begin
            state_s = ST_SET_NEW;
          end
          buf_s = '0;
          cnt_s = 3'd0;
          ovf_s = 1'b0;
        end else if (is_hash_s) begin
          if (full_entry_s) begin
            stored_s = buf_r;
            state_s  = ST_LOCKED;
          end else begin
            error_s  = 1'b1;
            state_s  = ST_SET_NEW;
          end
          buf_s = '0;
          cnt_s = 3'd0;
          ovf_s = 1'b0;
        end else begin
          state_s = ST_SET_NEW;
        end
      end

      ST_LOCKOUT: begin
        // Keys are ignored; timer value 1 means this is the last lockout cycle.
        if (timer_r <= 16'd1) begin
          state_s = ST_LOCKED;
          fail_s  = 4'd0;
          timer_s = 16'd0;
        end else begin
          timer_s = timer_r - 16'd1;
        end
      end

      default: begin
        state_s = ST_LOCKED;
      end
    endcase
  end

  // State, datapath and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_LOCKED;
      buf_r       <= '0;
      stored_r    <= RESET_CODE;
      cnt_r       <= 3'd0;
      ovf_r       <= 1'b0;
      timer_r     <= 16'd0;
      fail_r      <= 4'd0;
      locked      <= 1'b1;
      unlocked    <= 1'b0;
      set_mode    <= 1'b0;
      lockout     <= 1'b0;
      error       <= 1'b0;
      digit_count <= 3'd0;
      fail_count  <= 4'd0;
    end else begin
      state_r     <= state_s;
      buf_r       <= buf_s;
      stored_r    <= stored_s;
      cnt_r       <= cnt_s;
      ovf_r       <= ovf_s;
      timer_r     <= timer_s;
      fail_r      <= fail_s;
      locked      <= (state_s == ST_LOCKED) || (state_s == ST_LOCKOUT);
      unlocked    <= (state_s == ST_UNLOCKED) || (state_s == ST_SET_NEW);
      set_mode    <= (state_s == ST_SET_NEW);
      lockout     <= (state_s == ST_LOCKOUT);
      error       <= error_s;
      digit_count <= cnt_s;
      fail_count  <= fail_s;
    end
  end

endmodule
